// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size codes, store FSM states and alignment helper
// Purpose: common definitions for the load extender and the store narrowing unit.
//   SZ_*           2-bit access size codes (byte/half/word/illegal)
//   store_state_e  store FSM state encoding
//   is_misaligned  1 when (size, addr[1:0]) cannot be issued as a single access
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } store_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = (addr_lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - replicates a byte/half/word onto the word lanes and builds byte enables
// Purpose: combinational lane alignment for stores.
// Ports:
//   size_i     access size code (SZ_*)
//   addr_lo_i  byte offset inside the word
//   data_i     register value, byte/half in the low bits
//   wdata_o    data replicated across all lanes it may occupy
//   be_o       lane enables, bit i = data[8i+7:8i]; zero for an illegal size
module store_lane_align
  import mips_mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);

  logic [3:0] le_be;

  always_comb begin
    wdata_o = 32'h0;
    le_be   = 4'b0000;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        le_be   = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o = {2{data_i[15:0]}};
        le_be   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        wdata_o = data_i;
        le_be   = 4'b1111;
      end
      default: begin
        wdata_o = 32'h0;
        le_be   = 4'b0000;
      end
    endcase
  end

  // Replication already puts the bytes in big-endian order inside each lane pair,
  // so big-endian only needs the lane index mirrored.
  assign be_o = (BIG_ENDIAN != 0) ? {le_be[0], le_be[1], le_be[2], le_be[3]} : le_be;

endmodule

// File: rtl/store_narrow_unit.sv
// rtl/store_narrow_unit.sv - narrows, aligns and writes MEM-stage stores to data memory
// Purpose: accepts a store from the EX/MEM register, rejects misaligned sizes, and drives the
//   data-memory port with a req/ack handshake (single write, or read-modify-write when the
//   memory has no byte enables).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   st_valid/st_ready             store request handshake
//   st_size/st_addr/st_data       store size code, byte address, register value
//   mem_req/mem_we/mem_addr       memory request, write flag, word address
//   mem_wdata/mem_be              aligned write data and byte enables
//   mem_rdata/mem_ack             read data and request completion
//   done/misalign_err             one-cycle retire / reject pulses
module store_narrow_unit
  import mips_mem_pkg::*;
#(
  parameter int BYTE_EN_SUPPORT = 1,
  parameter int BIG_ENDIAN      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        misalign_err
);

  store_state_e state_q, state_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic [3:0]   lane_be_q, lane_be_d;
  logic         done_q, done_d;
  logic         mis_q, mis_d;

  logic [31:0]  align_wdata;
  logic [3:0]   align_be;
  logic [31:0]  merged;

  store_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .size_i   (st_size),
    .addr_lo_i(st_addr[1:0]),
    .data_i   (st_data),
    .wdata_o  (align_wdata),
    .be_o     (align_be)
  );

  // RMW merge: lanes being stored come from the aligned data still held in wdata_q,
  // the rest from the word just read back.
  always_comb begin
    merged = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = lane_be_q[i] ? wdata_q[i*8 +: 8] : mem_rdata[i*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    lane_be_d = lane_be_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (is_misaligned(st_size, st_addr[1:0])) begin
            // Reuse DONE as the one-cycle busy slot for the reject pulse.
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d    = {st_addr[31:2], 2'b00};
            wdata_d   = align_wdata;
            lane_be_d = align_be;
            req_d     = 1'b1;
            if (BYTE_EN_SUPPORT != 0) begin
              be_d    = align_be;
              we_d    = 1'b1;
              state_d = WR_REQ;
            end else begin
              be_d = 4'b1111;
              if (st_size == SZ_WORD) begin
                we_d    = 1'b1;
                state_d = WR_REQ;
              end else begin
                we_d    = 1'b0;
                state_d = RD_REQ;
              end
            end
          end
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          wdata_d = merged;
          we_d    = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      lane_be_q <= 4'b0000;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      lane_be_q <= lane_be_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
    end
  end

  assign st_ready     = (state_q == IDLE);
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign done         = done_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb/tb_store_narrow_unit.sv - randomized self-checking bench for store_narrow_unit
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_valid     [3];
  logic        st_ready     [3];
  logic        mem_req      [3];
  logic        mem_we       [3];
  logic [31:0] mem_addr     [3];
  logic [31:0] mem_wdata    [3];
  logic [3:0]  mem_be       [3];
  logic [31:0] mem_rdata    [3];
  logic        mem_ack      [3];
  logic        done         [3];
  logic        misalign_err [3];

  // Unit 0: byte enables, little endian; unit 1: read-modify-write; unit 2: byte enables, big endian.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    store_narrow_unit #(
      .BYTE_EN_SUPPORT((g == 1) ? 0 : 1),
      .BIG_ENDIAN     ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .st_valid    (st_valid[g]),
      .st_ready    (st_ready[g]),
      .st_size     (st_size),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .mem_req     (mem_req[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_be      (mem_be[g]),
      .mem_rdata   (mem_rdata[g]),
      .mem_ack     (mem_ack[g]),
      .done        (done[g]),
      .misalign_err(misalign_err[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Byte-addressed memories (64 bytes per unit): mem_b is what the memory port sees,
  // ref_b is the reference built from "store n bytes at address a".
  logic [7:0] mem_b [3][64];
  logic [7:0] ref_b [3][64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lane_off(input int u, input int lane);
    return (u == 2) ? 3 - lane : lane;
  endfunction

  function automatic logic [31:0] mem_read(input int u, input logic [31:0] a);
    logic [31:0] r;
    int base;
    base = int'(a[5:2]) * 4;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mem_b[u][base + lane_off(u, i)];
    return r;
  endfunction

  task automatic mem_write(input int u, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int base;
    base = int'(a[5:2]) * 4;
    for (int i = 0; i < 4; i++) if (be[i]) mem_b[u][base + lane_off(u, i)] = wd[8*i +: 8];
  endtask

  task automatic ref_store(input int u, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n;
    int base;
    n    = 1 << sz;
    base = int'(a[5:0]);
    for (int k = 0; k < n; k++)
      ref_b[u][base + k] = (u == 2) ? d[8*(n-1-k) +: 8] : d[8*k +: 8];
  endtask

  function automatic logic [3:0] exp_be(input int u, input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] r;
    int n;
    int off;
    r = 4'b0000;
    n = 1 << sz;
    if (u == 1) return 4'b1111;
    for (int k = 0; k < n; k++) begin
      off = (int'(a[1:0]) + k) & 3;
      r[(u == 2) ? 3 - off : off] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Issues one store at a negedge and plays the memory side; hold = cycles each request
  // stays up before ack (1 = ack in the first request cycle).
  task automatic do_store(input int u, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input logic mis,
                          output logic [31:0] w_wdata, output logic [3:0] w_be, output logic [31:0] w_addr,
                          output int done_cyc, output int n_req);
    int c;
    int nreq_cyc;
    logic new_req;
    logic ack_was;
    logic stable;
    logic [31:0] h_addr, h_wd;
    logic [3:0] h_be;
    logic h_we;
    w_wdata = 0; w_be = 0; w_addr = 0; done_cyc = 0; n_req = 0;
    h_addr = 0; h_wd = 0; h_be = 0; h_we = 0;
    check("ready_before", st_ready[u], 1);
    st_valid[u] = 1'b1; st_size = sz; st_addr = a; st_data = d;
    @(negedge clk);
    st_valid[u] = 1'b0;
    if (mis) begin
      check("mis_pulse", misalign_err[u], 1);
      check("mis_noreq", mem_req[u], 0);
      check("mis_busy", st_ready[u], 0);
      @(negedge clk);
      check("mis_ready", st_ready[u], 1);
      check("mis_clear", misalign_err[u], 0);
      check("mis_noreq2", mem_req[u], 0);
      return;
    end
    c = 1; nreq_cyc = 0; new_req = 1'b1; stable = 1'b1;
    while (c < 60 && done_cyc == 0) begin
      ack_was = mem_ack[u];
      mem_ack[u] = 1'b0;
      if (ack_was) new_req = 1'b1;
      if (done[u]) done_cyc = c;
      if (!mem_req[u] && !new_req) stable = 1'b0;
      if (mem_req[u]) begin
        if (new_req) begin
          new_req = 1'b0; n_req++; nreq_cyc = 0;
          h_addr = mem_addr[u]; h_wd = mem_wdata[u]; h_be = mem_be[u]; h_we = mem_we[u];
        end else if (mem_addr[u] !== h_addr || mem_wdata[u] !== h_wd || mem_be[u] !== h_be || mem_we[u] !== h_we) begin
          stable = 1'b0;
        end
        nreq_cyc++;
        if (nreq_cyc == hold) begin
          mem_ack[u] = 1'b1;
          if (!mem_we[u]) begin
            mem_rdata[u] = mem_read(u, mem_addr[u]);
          end else begin
            mem_write(u, mem_addr[u], mem_wdata[u], mem_be[u]);
            w_wdata = mem_wdata[u]; w_be = mem_be[u]; w_addr = mem_addr[u];
          end
        end
      end
      @(negedge clk);
      c++;
    end
    mem_ack[u] = 1'b0;
    check("done_seen", done_cyc != 0, 1);
    check("done_pulse", done[u], 0);
    check("ready_after", st_ready[u], 1);
    check("req_stable", stable, 1);
  endtask

  task automatic run_store(input int u, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input int hold, output logic [31:0] w_wdata, output logic [3:0] w_be);
    logic mis;
    logic rmw;
    logic [31:0] w_addr;
    logic [31:0] got_w, exp_w;
    int done_cyc;
    int n_req;
    int base;
    mis = is_mis(sz, a);
    if (!mis) ref_store(u, sz, a, d);
    do_store(u, sz, a, d, hold, mis, w_wdata, w_be, w_addr, done_cyc, n_req);
    if (!mis) begin
      rmw = (u == 1) && (sz != 2'b10);
      check("done_cycle", done_cyc, rmw ? 2*hold + 1 : hold + 1);
      check("req_count", n_req, rmw ? 2 : 1);
      check("mem_addr", w_addr, {a[31:2], 2'b00});
      check("mem_be", {28'h0, w_be}, {28'h0, exp_be(u, sz, a)});
      base = int'(a[5:2]) * 4;
      for (int k = 0; k < 4; k++) begin
        got_w[8*k +: 8] = mem_b[u][base + k];
        exp_w[8*k +: 8] = ref_b[u][base + k];
      end
      check("mem_word", got_w, exp_w);
    end
  endtask

  initial begin
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  sz;
    logic [31:0] a;
    int u;

    for (int i = 0; i < 3; i++) begin
      st_valid[i] = 1'b0; mem_ack[i] = 1'b0; mem_rdata[i] = 32'h0;
      for (int j = 0; j < 64; j++) begin
        mem_b[i][j] = 8'($urandom);
        ref_b[i][j] = mem_b[i][j];
      end
    end
    st_size = 2'b10; st_addr = 32'h0; st_data = 32'h0;

    // Reset, with a request held on unit 0 that must be ignored.
    rst_n = 1'b0;
    st_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_req", mem_req[i], 0);
      check("rst_we", mem_we[i], 0);
      check("rst_done", done[i], 0);
      check("rst_mis", misalign_err[i], 0);
      check("rst_addr", mem_addr[i], 0);
      check("rst_wdata", mem_wdata[i], 0);
      check("rst_be", {28'h0, mem_be[i]}, 0);
    end
    rst_n = 1'b1;
    st_valid[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("ready_post_rst", st_ready[i], 1);
      check("req_post_rst", mem_req[i], 0);
    end

    // sb 0x1003, zero-wait
    run_store(0, 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 1, wd, be);
    check("sb_wdata", wd, 32'hDDDD_DDDD);
    check("sb_be", {28'h0, be}, 32'h8);

    // sh 0x2002, three-cycle ack delay
    run_store(0, 2'b01, 32'h0000_2002, 32'h0000_1234, 3, wd, be);
    check("sh_wdata", wd, 32'h1234_1234);
    check("sh_be", {28'h0, be}, 32'hC);

    // RMW sb 0x3001 over 0x11223344
    mem_b[1][0] = 8'h44; mem_b[1][1] = 8'h33; mem_b[1][2] = 8'h22; mem_b[1][3] = 8'h11;
    for (int j = 0; j < 4; j++) ref_b[1][j] = mem_b[1][j];
    run_store(1, 2'b00, 32'h0000_3001, 32'h0000_005A, 1, wd, be);
    check("rmw_wdata", wd, 32'h1122_5A44);
    check("rmw_be", {28'h0, be}, 32'hF);

    // Misaligned requests
    run_store(0, 2'b01, 32'h0000_0001, 32'h1, 1, wd, be);
    run_store(0, 2'b10, 32'h0000_0006, 32'h2, 1, wd, be);
    run_store(0, 2'b11, 32'h0000_0000, 32'h3, 1, wd, be);
    run_store(1, 2'b01, 32'h0000_0003, 32'h4, 1, wd, be);

    // Big-endian sb 0x0000
    run_store(2, 2'b00, 32'h0000_0000, 32'h0000_0077, 1, wd, be);
    check("be_wdata", wd, 32'h7777_7777);
    check("be_be", {28'h0, be}, 32'h8);

    // Reset while a write waits for ack, with ack in the same cycle as reset
    st_valid[0] = 1'b1; st_size = 2'b10; st_addr = 32'h0000_0080; st_data = 32'h0BAD_F00D;
    @(negedge clk);
    st_valid[0] = 1'b0;
    @(negedge clk);
    check("mid_req", mem_req[0], 1);
    check("mid_we", mem_we[0], 1);
    rst_n = 1'b0;
    mem_ack[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_req", mem_req[0], 0);
    check("mid_rst_done", done[0], 0);
    mem_ack[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_done2", done[0], 0);
    check("mid_rst_ready", st_ready[0], 1);
    run_store(0, 2'b10, 32'h0000_0040, 32'hCAFE_BABE, 2, wd, be);
    check("after_rst_wdata", wd, 32'hCAFE_BABE);

    // Randomized stores on all three units
    for (int t = 0; t < 80; t++) begin
      u  = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_store(u, sz, a, $urandom, $urandom_range(1, 3), wd, be);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
